// File: rtl/writeback_arbiter_if.sv
// Register-file write-side bundle: ALU result input, LSU valid/ready result input,
// and the registered single write port toward the 32x64 register file.
interface writeback_arbiter_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH + 1);

  logic          alu_valid;
  logic [4:0]    alu_rd;
  logic [63:0]   alu_data;
  logic          alu_stall;
  logic          lsu_valid;
  logic          lsu_ready;
  logic [4:0]    lsu_rd;
  logic [63:0]   lsu_data;
  logic          RegWrite;
  logic [4:0]    WriteReg;
  logic [63:0]   WriteData;
  logic [CW-1:0] fifo_count;

  // Producer side: pipeline front-end / testbench.
  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_stall, lsu_ready, RegWrite, WriteReg, WriteData, fifo_count
  );

  // Arbiter side.
  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_stall, lsu_ready, RegWrite, WriteReg, WriteData, fifo_count
  );
endinterface

// File: rtl/writeback_arbiter.sv
// Merges single-cycle ALU results and FIFO-buffered LSU results into one registered
// register-file write port; ALU has priority, bounded by a starvation counter.
module writeback_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 3
) (
  input  logic               clk,
  input  logic               rst,
  writeback_arbiter_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  typedef struct packed {
    logic [4:0]  rd;
    logic [63:0] data;
  } entry_t;

  entry_t mem [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [SW-1:0] starve_q, starve_d;
  logic          reg_write_q, reg_write_d;
  logic [4:0]    write_reg_q, write_reg_d;
  logic [63:0]   write_data_q, write_data_d;

  logic   fifo_empty;
  logic   alu_stall;
  logic   lsu_ready;
  logic   alu_win;
  logic   push;
  logic   pop;
  entry_t head;

  assign fifo_empty = (count_q == '0);
  assign alu_stall  = (starve_q == SW'(STARVE_LIMIT));
  assign lsu_ready  = !rst && (count_q < CW'(DEPTH));
  assign head       = mem[rd_ptr_q];

  // rd==0 results are architecturally void: ALU ones lose arbitration, LSU ones
  // complete the handshake without occupying a slot.
  assign alu_win = bus.alu_valid && (bus.alu_rd != 5'd0) && !alu_stall;
  assign push    = bus.lsu_valid && lsu_ready && (bus.lsu_rd != 5'd0);
  assign pop     = !alu_win && !fifo_empty;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    starve_d     = starve_q;
    reg_write_d  = 1'b0;
    write_reg_d  = 5'd0;
    write_data_d = 64'd0;

    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (alu_win) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.alu_rd;
      write_data_d = bus.alu_data;
    end else if (pop) begin
      reg_write_d  = 1'b1;
      write_reg_d  = head.rd;
      write_data_d = head.data;
    end

    // Only ALU wins over a waiting FIFO count toward starvation.
    if (pop || fifo_empty) starve_d = '0;
    else if (alu_win)      starve_d = starve_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      starve_q     <= '0;
      reg_write_q  <= 1'b0;
      write_reg_q  <= 5'd0;
      write_data_q <= 64'd0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      starve_q     <= starve_d;
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
    end
  end

  // Storage carries no reset; validity is tracked solely by the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= '{rd: bus.lsu_rd, data: bus.lsu_data};
  end

  assign bus.alu_stall  = alu_stall;
  assign bus.lsu_ready  = lsu_ready;
  assign bus.RegWrite   = reg_write_q;
  assign bus.WriteReg   = write_reg_q;
  assign bus.WriteData  = write_data_q;
  assign bus.fifo_count = count_q;
endmodule

// File: tb/tb_writeback_arbiter.sv
// Scenario bench for writeback_arbiter: a behavioural model queues the expected
// register-file write for every edge; each scenario pops and compares it.
module tb_writeback_arbiter;
  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 3;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  logic [69:0] exp_q [$];   // {RegWrite, WriteReg, WriteData}
  logic [68:0] m_q   [$];   // model FIFO {rd, data}
  int          m_starve = 0;

  writeback_arbiter_if #(.DEPTH(DEPTH)) dut_if ();

  writeback_arbiter #(.DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (dut_if)
  );

  always #5 clk = ~clk;

  // Model the edge from the inputs currently driven, then advance past it.
  task automatic clk_edge();
    logic [69:0] e;
    bit stall;
    bit ready;
    bit win;
    stall = (m_starve == STARVE_LIMIT);
    ready = !rst && (m_q.size() < DEPTH);
    win   = dut_if.alu_valid && (dut_if.alu_rd != 5'd0) && !stall;
    if (rst) begin
      m_q.delete();
      m_starve = 0;
      e = '0;
    end else begin
      if (win) begin
        e = {1'b1, dut_if.alu_rd, dut_if.alu_data};
        m_starve = (m_q.size() != 0) ? m_starve + 1 : 0;
      end else if (m_q.size() != 0) begin
        e = {1'b1, m_q.pop_front()};
        m_starve = 0;
      end else begin
        e = '0;
        m_starve = 0;
      end
      if (dut_if.lsu_valid && ready && (dut_if.lsu_rd != 5'd0))
        m_q.push_back({dut_if.lsu_rd, dut_if.lsu_data});
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    dut_if.alu_valid = 1'b0;
    dut_if.alu_rd    = 5'd0;
    dut_if.alu_data  = 64'd0;
    dut_if.lsu_valid = 1'b0;
    dut_if.lsu_rd    = 5'd0;
    dut_if.lsu_data  = 64'd0;
  endtask

  task automatic test_reset();
    logic [69:0] e;
    rst = 1'b1;
    idle_inputs();
    for (int c = 0; c < 2; c++) begin
      clk_edge();
      e = exp_q.pop_front();
      n_vec++;
      if ({dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== e) begin
        n_err++;
        $display("FAIL reset_write: got %h want %h", {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData}, e);
      end
      n_vec++;
      if (dut_if.fifo_count !== 3'd0 || dut_if.lsu_ready !== 1'b0) begin
        n_err++;
        $display("FAIL reset_state: count=%0d ready=%b want 0/0", dut_if.fifo_count, dut_if.lsu_ready);
      end
    end
    rst = 1'b0;
    #1;
    n_vec++;
    if (dut_if.lsu_ready !== 1'b1 || dut_if.alu_stall !== 1'b0) begin
      n_err++;
      $display("FAIL post_reset: ready=%b stall=%b want 1/0", dut_if.lsu_ready, dut_if.alu_stall);
    end
    clk_edge();
    e = exp_q.pop_front();
    n_vec++;
    if ({dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== e) begin
      n_err++;
      $display("FAIL idle_write: got %h want %h", {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData}, e);
    end
    $display("txn reset: idle we=%b", dut_if.RegWrite);
  endtask

  task automatic test_alu();
    logic [69:0] e;
    dut_if.alu_valid = 1'b1;
    dut_if.alu_rd    = 5'd5;
    dut_if.alu_data  = 64'h1234;
    clk_edge();
    e = exp_q.pop_front();
    n_vec++;
    if ({dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== {1'b1, 5'd5, 64'h1234} || e !== {1'b1, 5'd5, 64'h1234}) begin
      n_err++;
      $display("FAIL alu_write: got %h want %h", {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData}, e);
    end
    $display("txn alu: we=%b rd=%0d data=%h", dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData);
    idle_inputs();
    clk_edge();
    e = exp_q.pop_front();
    n_vec++;
    if ({dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== e) begin
      n_err++;
      $display("FAIL alu_idle: got %h want %h", {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData}, e);
    end
  endtask

  task automatic test_lsu();
    logic [69:0] e;
    dut_if.lsu_valid = 1'b1;
    dut_if.lsu_rd    = 5'd7;
    dut_if.lsu_data  = 64'hDEAD;
    clk_edge();
    idle_inputs();
    e = exp_q.pop_front();
    n_vec++;
    if (dut_if.RegWrite !== 1'b0 || dut_if.fifo_count !== 3'd1 || e[69] !== 1'b0) begin
      n_err++;
      $display("FAIL lsu_accept: we=%b count=%0d want 0/1", dut_if.RegWrite, dut_if.fifo_count);
    end
    clk_edge();
    e = exp_q.pop_front();
    n_vec++;
    if ({dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== {1'b1, 5'd7, 64'hDEAD} || dut_if.fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL lsu_write: got %h count=%0d want %h count=0", {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData}, dut_if.fifo_count, e);
    end
    $display("txn lsu: we=%b rd=%0d data=%h", dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData);
  endtask

  task automatic test_rd0();
    logic [69:0] e;
    dut_if.lsu_valid = 1'b1;
    dut_if.lsu_rd    = 5'd0;
    dut_if.lsu_data  = 64'h55;
    clk_edge();
    idle_inputs();
    dut_if.alu_valid = 1'b1;
    dut_if.alu_data  = 64'h66;
    e = exp_q.pop_front();
    n_vec++;
    if (dut_if.fifo_count !== 3'd0 || {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== e) begin
      n_err++;
      $display("FAIL rd0_lsu: count=%0d we=%b want 0/0", dut_if.fifo_count, dut_if.RegWrite);
    end
    clk_edge();
    idle_inputs();
    e = exp_q.pop_front();
    n_vec++;
    if (dut_if.RegWrite !== 1'b0 || {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== e) begin
      n_err++;
      $display("FAIL rd0_alu: we=%b rd=%0d want 0", dut_if.RegWrite, dut_if.WriteReg);
    end
    $display("txn rd0: count=%0d we=%b", dut_if.fifo_count, dut_if.RegWrite);
  endtask

  task automatic test_collision();
    logic [69:0] e;
    int  lsu_i = 0;
    int  rd = 1;
    int  stalls = 0;
    bit  win;
    bit  acc;
    for (int c = 0; c < 20; c++) begin
      dut_if.alu_valid = 1'b1;
      dut_if.alu_rd    = 5'(rd);
      dut_if.alu_data  = 64'hA000 + 64'(rd);
      dut_if.lsu_valid = (lsu_i < 4);
      dut_if.lsu_rd    = 5'(10 + lsu_i);
      dut_if.lsu_data  = 64'hB000 + 64'(lsu_i);
      win = (m_starve != STARVE_LIMIT);
      acc = (lsu_i < 4) && (m_q.size() < DEPTH);
      clk_edge();
      if (win) rd++;
      if (acc) lsu_i++;
      e = exp_q.pop_front();
      n_vec++;
      if ({dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== e) begin
        n_err++;
        $display("FAIL coll_write[%0d]: got %h want %h", c, {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData}, e);
      end
      n_vec++;
      if (dut_if.alu_stall !== (m_starve == STARVE_LIMIT) || dut_if.lsu_ready !== (m_q.size() < DEPTH)
          || dut_if.fifo_count !== 3'(m_q.size())) begin
        n_err++;
        $display("FAIL coll_state[%0d]: stall=%b ready=%b count=%0d want %b/%b/%0d", c, dut_if.alu_stall,
                 dut_if.lsu_ready, dut_if.fifo_count, m_starve == STARVE_LIMIT, m_q.size() < DEPTH, m_q.size());
      end
      if (dut_if.alu_stall === 1'b1) stalls++;
      $display("txn coll %0d: we=%b rd=%0d data=%h", c, dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData);
    end
    n_vec++;
    if (stalls != 4 || lsu_i != 4 || dut_if.fifo_count !== 3'd0) begin
      n_err++;
      $display("FAIL coll_summary: stalls=%0d accepted=%0d count=%0d want 4/4/0", stalls, lsu_i, dut_if.fifo_count);
    end
    idle_inputs();
    clk_edge();
    e = exp_q.pop_front();
    n_vec++;
    if ({dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== e) begin
      n_err++;
      $display("FAIL coll_tail: got %h want %h", {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData}, e);
    end
  endtask

  task automatic test_reset_mid();
    logic [69:0] e;
    for (int c = 0; c < 3; c++) begin
      dut_if.alu_valid = 1'b1;
      dut_if.alu_rd    = 5'(20 + c);
      dut_if.alu_data  = 64'hC0 + 64'(c);
      dut_if.lsu_valid = 1'b1;
      dut_if.lsu_rd    = 5'(25 + c);
      dut_if.lsu_data  = 64'hD0 + 64'(c);
      clk_edge();
      e = exp_q.pop_front();
      n_vec++;
      if ({dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData} !== e) begin
        n_err++;
        $display("FAIL mid_fill[%0d]: got %h want %h", c, {dut_if.RegWrite, dut_if.WriteReg, dut_if.WriteData}, e);
      end
    end
    n_vec++;
    if (dut_if.fifo_count !== 3'd3) begin
      n_err++;
      $display("FAIL mid_count: got %0d want 3", dut_if.fifo_count);
    end
    idle_inputs();
    rst = 1'b1;
    clk_edge();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) clk_edge();
      e = exp_q.pop_front();
      n_vec++;
      if (dut_if.RegWrite !== 1'b0 || dut_if.fifo_count !== 3'd0 || e !== 70'd0) begin
        n_err++;
        $display("FAIL mid_after[%0d]: we=%b count=%0d want 0/0", c, dut_if.RegWrite, dut_if.fifo_count);
      end
    end
    $display("txn reset_mid: count=%0d we=%b", dut_if.fifo_count, dut_if.RegWrite);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lsu();
    test_rd0();
    test_collision();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writer-side companion to the 32x64 integer register file.
- Merges two result sources into the file's single write port (RegWrite/WriteReg/WriteData):
  - single-cycle ALU results, never back-pressured except by alu_stall;
  - variable-latency load/long-op (LSU) results through a valid/ready handshake and a small FIFO.
- Output is registered, so the register file sees one write per cycle.

Parameters:
- DEPTH, 4, LSU result FIFO entries; power of two, >= 2
- STARVE_LIMIT, 3, consecutive ALU-won cycles with a non-empty FIFO before alu_stall asserts; >= 1

Ports:
- clk  in  1  clock, all state updates on posedge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle
- alu_rd  in  5  ALU destination register
- alu_data  in  64  ALU result
- alu_stall  out  1  upstream must hold ALU result; alu_valid ignored this cycle
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept; transfer when lsu_valid & lsu_ready
- lsu_rd  in  5  LSU destination register
- lsu_data  in  64  LSU result
- RegWrite  out  1  write enable to register file
- WriteReg  out  5  write address
- WriteData  out  64  write data
- fifo_count  out  $clog2(DEPTH+1)  current FIFO occupancy

Behaviour:
- Reset (rst=1 at posedge):
  - RegWrite=0, WriteReg=0, WriteData=0, fifo_count=0.
  - FIFO pointers cleared; starve counter=0; alu_stall=0.
  - lsu_ready=0 combinationally while rst=1.
  - Entries in flight are discarded; reset mid-operation loses queued LSU results by design.
- lsu_ready = !rst && (fifo_count < DEPTH). Combinational from registered state only; no dependence on lsu_valid.
- LSU handshake:
  - Accepted when lsu_valid && lsu_ready at posedge.
  - If lsu_rd==0: the handshake completes but nothing is enqueued.
  - Otherwise {lsu_rd, lsu_data} is pushed at the tail.
  - No bypass: an entry accepted at edge N is poppable at edge N+1 and visible on the outputs after edge N+1, so minimum LSU latency is 2 edges.
- ALU write is eligible when alu_valid && alu_rd!=0 && !alu_stall. alu_rd==0 is ignored and the FIFO may drain that cycle.
- Selection at each posedge, in priority order:
  1. Eligible ALU write: RegWrite<=1, WriteReg<=alu_rd, WriteData<=alu_data.
  2. FIFO non-empty: pop head; RegWrite<=1, WriteReg/WriteData <= head fields.
  3. Otherwise RegWrite<=0, WriteReg<=0, WriteData<=0.
- ALU latency is 1 edge (input at edge N, on outputs after edge N).
- Simultaneous push and pop at edge N leaves fifo_count unchanged; a push on a full FIFO cannot occur because ready=0. Pointers wrap modulo DEPTH.
- Starvation control:
  - Starve counter increments at each edge where the FIFO is non-empty and the ALU wins.
  - It resets to 0 on any pop or when the FIFO is empty.
  - alu_stall = (starve counter == STARVE_LIMIT), registered state only.
  - While alu_stall=1 the FIFO pops; the counter then returns to 0 and alu_stall deasserts the next cycle.
- Write ordering between the ALU and the LSU to the same rd is not resolved here. The hazard/issue logic must guarantee that ordering.
- The block never emits RegWrite=1 with WriteReg=0.

Test Plan:
- Reset then idle:
  - Stimulus: rst=1 for 2 cycles, then release with no inputs.
  - Required: RegWrite=0, WriteReg=0, WriteData=0, fifo_count=0, lsu_ready=0 during rst and 1 after, alu_stall=0.
- ALU path:
  - Stimulus: alu_valid=1, rd=5, data=0x1234 at edge N.
  - Required: after N, RegWrite=1, WriteReg=5, WriteData=0x1234. After N+1 with no input, RegWrite=0.
- LSU path:
  - Stimulus: lsu rd=7, data=0xDEAD accepted at edge N, no ALU traffic.
  - Required: fifo_count=1 after N; write of reg 7 = 0xDEAD after N+1; fifo_count=0.
- Collision and back-pressure:
  - Stimulus: ALU valid every cycle (rd=1..), 4 LSU results pushed, DEPTH=4.
  - Required: lsu_ready=0 at count 4.
  - Required: after 3 consecutive ALU writes with a non-empty FIFO, alu_stall=1 for one cycle and an LSU entry is written in FIFO order.
  - Required: all 4 LSU entries are eventually written with no loss or duplication.
- rd=0 filtering:
  - Stimulus: LSU rd=0 accepted, then ALU rd=0 valid.
  - Required: fifo_count stays 0; RegWrite stays 0.
- Reset mid-operation:
  - Stimulus: FIFO holds 3 entries, assert rst for 1 cycle.
  - Required: fifo_count=0, no queued entries written afterwards, RegWrite=0 after the reset edge.
